mmio_seg7_ctrl: RTL
===================

# mmio_seg7_ctrl

Memory-mapped eight-digit seven-segment display controller on the CPU54 data-memory bus, downstream of the multicycle core. It decodes CPU stores/loads in a 16-byte window at the I/O page, holds a 32-bit hex display register and a control register, and time-multiplexes the eight digits with a free-running prescaler and scan counter.

## Interface
- CLK_DIV, 100000: clk cycles each digit stays lit; legal range 1..2^24-1.
- BASE_ADDR, 32'h10010000: byte address of register 0; 16-byte aligned.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- addr  in  32  byte address from the core's Z register (ALU result).
- wdata  in  32  store data, full word.
- we  in  1  data-memory write strobe from the controller.
- rdata  out  32  combinational read data; 0 when hit=0.
- hit  out  1  combinational; 1 when addr is in BASE_ADDR..BASE_ADDR+0x0B.
- seg  out  7  active-low segments {g,f,e,d,c,b,a}, registered.
- dp  out  1  active-low decimal point, registered.
- an  out  8  active-low digit anodes, an[0] = rightmost digit, registered.

## Operation
- Register map (offset = addr - BASE_ADDR, addr[1:0] ignored): 0x00 DATA (rw, nibble i → digit i); 0x04 CTRL (rw, [7:0] digit enable mask, [15:8] dp mask, [31:16] read 0, writes ignored); 0x08 STATUS (ro, [2:0] scan index, [31:16] frame count, other bits 0). Offset 0x0C and above: hit=0.
- Write: at a clk edge with we=1, hit=1 the addressed register takes wdata. Writes to STATUS are dropped. Stores are word-only; sub-word merging is done by the core.
- Prescaler: counts 0..CLK_DIV-1 and wraps. On the wrap edge, scan index increments mod 8. On index 7→0, the frame count increments mod 2^16.
- Output register, every edge: digit d = current index.
  - an = all ones except bit d, which is 0 when CTRL[d]=1.
  - seg = glyph(DATA[4d+3:4d]).
  - dp = ~CTRL[8+d].
- Glyphs (hex): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- Reset values: DATA=0, CTRL=0x000000FF, prescaler=0, index=0, frame=0, an=8'hFF, seg=7'h7F, dp=1.

## Timing
- Register write is captured at edge N. The display reflects it at edge N+1 if the index selects that digit.
- Read is zero-latency, combinational from the current register state. A load during the write edge returns the old value.
- Index advance and register write at the same edge: the output at the following edge uses both the new index and the new contents. There are no priority conflicts.
- CLK_DIV=1: the index advances every edge.
- Reset asserted mid-scan: outputs go to their reset values without waiting for clk. The first lit digit (index 0) appears at the first edge after release.
- One full frame = 8·CLK_DIV cycles.

## Configuration
- SEG7_LEADING_ZERO_BLANK_EN defined: digit d is additionally blanked (an[d]=1, dp=1) when d>0 and DATA[31:4d] is all zero. Digit 0 is never blanked by this rule. The rule ANDs with the CTRL mask.
- Undefined: only the CTRL mask gates digits; leading zeros display as "0".

## Test plan
- Reset: assert reset mid-scan, asynchronous to clk → an=FF, seg=7F, dp=1 immediately. After release, read 0x10010000 → 0 and 0x10010004 → 0x000000FF.
- Scan: CLK_DIV=4, write DATA=0x1234ABCD → over 32 cycles an walks FE,FD,…,7F with seg 21,46,03,08,19,30,24,79. Each digit holds for 4 cycles.
- Masks: write CTRL=0x00000F0F → an[7:4] stay 1 throughout, and dp=0 only while digits 0–3 are lit. Read back CTRL → 0x00000F0F.
- Decode: write to 0x10010008 → STATUS unchanged. At 0x1001000C, hit=0, rdata=0, and no register changes. STATUS[31:16] reads 1 after 8·CLK_DIV cycles from reset.
- Same-edge: write DATA on the exact prescaler wrap edge → the next output shows the new index with the new nibble.
- Macro: DATA=0x000000A5. With SEG7_LEADING_ZERO_BLANK_EN, only an[1:0] are ever driven low. Without it, all 8 anodes are driven low in turn and digits 2–7 show seg=40.

Source files
------------

// File: rtl/mmio_seg7_ctrl.sv
// Memory-mapped eight-digit seven-segment controller: DATA/CTRL/STATUS registers plus scan multiplexing.
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module mmio_seg7_ctrl #(
    parameter int          CLK_DIV   = 100000,
    parameter logic [31:0] BASE_ADDR = 32'h10010000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic        hit,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  an
);

    localparam logic [23:0] DIV_LAST = 24'(CLK_DIV - 1);

    logic [31:0] r_data;
    logic [15:0] r_ctrl;
    logic [23:0] r_presc;
    logic [2:0]  r_idx;
    logic [15:0] r_frame;
    logic [6:0]  r_seg;
    logic        r_dp;
    logic [7:0]  r_an;

    logic        w_hit;
    logic [1:0]  w_reg_sel;
    logic        w_wrap;
    logic [3:0]  w_nib;
    logic [7:0]  w_dp_mask;
    logic        w_lz_blank;
    logic        w_lit;
    logic [7:0]  w_an;
    logic        w_dp;

    function automatic logic [6:0] f_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h10;
            4'hA:    g = 7'h08;
            4'hB:    g = 7'h03;
            4'hC:    g = 7'h46;
            4'hD:    g = 7'h21;
            4'hE:    g = 7'h06;
            4'hF:    g = 7'h0E;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    // Address decode and combinational read mux; offset 0x0C is outside the window.
    always_comb begin
        w_reg_sel = addr[3:2];
        w_hit     = (addr[31:4] == BASE_ADDR[31:4]) && (addr[3:2] != 2'b11);
        rdata     = 32'd0;
        if (w_hit) begin
            case (w_reg_sel)
                2'b00:   rdata = r_data;
                2'b01:   rdata = {16'd0, r_ctrl};
                2'b10:   rdata = {r_frame, 13'd0, r_idx};
                default: rdata = 32'd0;
            endcase
        end else begin
            rdata = 32'd0;
        end
        hit = w_hit;
    end

    // CPU store into DATA or CTRL; stores to STATUS are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= 32'd0;
            r_ctrl <= 16'h00FF;
        end else if (we && w_hit) begin
            case (w_reg_sel)
                2'b00:   r_data <= wdata;
                2'b01:   r_ctrl <= wdata[15:0];
                default: r_data <= r_data;
            endcase
        end
    end

    assign w_wrap = (r_presc == DIV_LAST);

    // Free-running prescaler, scan index and frame counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= 24'd0;
            r_idx   <= 3'd0;
            r_frame <= 16'd0;
        end else if (w_wrap) begin
            r_presc <= 24'd0;
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
                r_frame <= r_frame + 16'd1;
            end
        end else begin
            r_presc <= r_presc + 24'd1;
        end
    end

    // Digit drive for the current scan index, taken from pre-edge register contents.
    always_comb begin
        w_nib      = r_data[{r_idx, 2'b00} +: 4];
        w_dp_mask  = r_ctrl[15:8];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        w_lz_blank = (r_idx != 3'd0) && ((r_data >> {r_idx, 2'b00}) == 32'd0);
`else
        w_lz_blank = 1'b0;
`endif
        w_lit = r_ctrl[r_idx] && !w_lz_blank;
        w_an  = 8'hFF;
        if (w_lit) begin
            w_an[r_idx] = 1'b0;
        end else begin
            w_an = 8'hFF;
        end
        w_dp = !w_dp_mask[r_idx] || w_lz_blank;
    end

    // Registered display outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an  <= 8'hFF;
            r_seg <= 7'h7F;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an;
            r_seg <= f_glyph(w_nib);
            r_dp  <= w_dp;
        end
    end

    assign seg = r_seg;
    assign dp  = r_dp;
    assign an  = r_an;

endmodule
